// File: rtl/digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_addsub
// Purpose  : Digit-serial adder/subtractor. Operands arrive least-significant
//            digit first, one DIGIT_W-bit digit pair per valid beat, framed
//            by vld/last. The add/subtract choice is taken from the first
//            beat of each word. The final carry, signed overflow, word
//            length and a truncation flag are reported with the last result
//            digit.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-low reset
//            vld       - input beat valid
//            last      - final digit of word (qualified by vld)
//            sub       - 0: a+b, 1: a-b (sampled on first beat only)
//            a, b      - operand digits
//            out_vld   - result digit valid
//            out_sum   - result digit
//            out_last  - final result digit of word
//            out_carry - carry out (add) / no-borrow (sub), with out_last
//            out_ovf   - two's-complement overflow of word, with out_last
//            out_err   - word exceeded MAX_DIGITS and was truncated
//            out_len   - number of digits in the emitted word, with out_last
// Revision : 1.0 - initial release
// ============================================================================
module digit_serial_addsub #(
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGITS = 8,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic               last,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               out_vld,
  output logic [DIGIT_W-1:0] out_sum,
  output logic               out_last,
  output logic               out_carry,
  output logic               out_ovf,
  output logic               out_err,
  output logic [CNT_W-1:0]   out_len
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  state_t             state_q;
  logic               carry_q;
  logic               op_sub_q;
  logic [CNT_W-1:0]   count_q;

  logic               w_first;
  logic               w_op;
  logic [DIGIT_W-1:0] w_b_eff;
  logic               w_cin;
  logic [DIGIT_W:0]   w_full;
  logic [DIGIT_W-1:0] w_s;
  logic               w_c;
  logic               w_msb_cin;
  logic [CNT_W-1:0]   w_beat;
  logic               w_trunc;
  logic               w_end;

  always_comb begin
    w_first   = (state_q == S_IDLE);
    w_op      = w_first ? sub : op_sub_q;
    w_b_eff   = w_op ? ~b : b;
    // Subtraction is a + ~b + 1: the +1 enters as carry-in of the first digit.
    w_cin     = w_first ? w_op : carry_q;
    w_full    = {1'b0, a} + {1'b0, w_b_eff} + {{DIGIT_W{1'b0}}, w_cin};
    w_s       = w_full[DIGIT_W-1:0];
    w_c       = w_full[DIGIT_W];
    // Carry into the digit MSB, recovered from the MSB sum bit.
    w_msb_cin = a[DIGIT_W-1] ^ w_b_eff[DIGIT_W-1] ^ w_s[DIGIT_W-1];
    w_beat    = w_first ? CNT_W'(1) : count_q + CNT_W'(1);
    // A word reaching MAX_DIGITS without last is cut off at this digit.
    w_trunc   = !last && (w_beat == CNT_W'(MAX_DIGITS));
    w_end     = last || w_trunc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      carry_q   <= 1'b0;
      op_sub_q  <= 1'b0;
      count_q   <= '0;
      out_vld   <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
      out_len   <= '0;
    end else begin
      // Strobes default low; sum/carry/ovf/len hold their last value.
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_err  <= 1'b0;
      if (vld) begin
        if (state_q == S_DROP) begin
          // Remainder of a truncated word is discarded up to its last beat.
          if (last) begin
            state_q <= S_IDLE;
          end
        end else begin
          out_vld <= 1'b1;
          out_sum <= w_s;
          count_q <= w_beat;
          if (w_first) begin
            op_sub_q <= sub;
          end
          if (w_end) begin
            out_last  <= 1'b1;
            out_carry <= w_c;
            out_ovf   <= w_msb_cin ^ w_c;
            out_len   <= w_beat;
            out_err   <= w_trunc;
            carry_q   <= 1'b0;
            state_q   <= last ? S_IDLE : S_DROP;
          end else begin
            carry_q <= w_c;
            state_q <= S_ACTIVE;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_serial_addsub
// Purpose  : Self-checking bench for digit_serial_addsub (DIGIT_W=4,
//            MAX_DIGITS=4). Directed scenarios plus randomized words checked
//            against a whole-word arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_serial_addsub;

  localparam int W    = 4;
  localparam int MAXD = 4;
  localparam int CW   = $clog2(MAXD + 1);

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          vld  = 1'b0;
  logic          last = 1'b0;
  logic          sub  = 1'b0;
  logic [W-1:0]  a    = '0;
  logic [W-1:0]  b    = '0;
  logic          out_vld;
  logic [W-1:0]  out_sum;
  logic          out_last;
  logic          out_carry;
  logic          out_ovf;
  logic          out_err;
  logic [CW-1:0] out_len;

  digit_serial_addsub #(
    .DIGIT_W    (W),
    .MAX_DIGITS (MAXD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vld       (vld),
    .last      (last),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .out_vld   (out_vld),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_err   (out_err),
    .out_len   (out_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  sum;
    logic          lst;
    logic          carry;
    logic          ovf;
    logic          err;
    logic [CW-1:0] len;
  } out_t;

  out_t         got_q[$];
  out_t         exp_q[$];
  logic [W-1:0] wa[0:15];
  logic [W-1:0] wb[0:15];
  int           total = 0;
  int           bad   = 0;

  // Capture every valid output digit away from the active edge.
  always @(negedge clk) begin
    if (rst && out_vld) begin
      got_q.push_back('{out_sum, out_last, out_carry, out_ovf, out_err, out_len});
    end
  end

  // One accepted input beat; returns at posedge+1 with vld low.
  task automatic beat(input logic l, input logic s, input logic [W-1:0] av,
                      input logic [W-1:0] bv);
    vld = 1'b1; last = l; sub = s; a = av; b = bv;
    @(posedge clk); #1;
    vld = 1'b0; last = 1'b0;
  endtask

  // Idle cycles with junk on the data pins and stray last pulses.
  task automatic idle(input int n);
    repeat (n) begin
      vld = 1'b0; last = 1'($urandom); sub = 1'($urandom);
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
    end
    last = 1'b0;
  endtask

  // Whole-word reference: operands as integers, truncated to MAXD digits.
  task automatic model_word(input int n, input logic s);
    int     k;
    int     nb;
    longint va, vb, r, mask, half, sa, sb, t;
    logic   cy, ov;
    k  = (n > MAXD) ? MAXD : n;
    nb = k * W;
    va = 0; vb = 0;
    for (int i = 0; i < k; i++) begin
      va = va | (longint'(wa[i]) << (W * i));
      vb = vb | (longint'(wb[i]) << (W * i));
    end
    mask = (longint'(1) << nb) - 1;
    half = longint'(1) << (nb - 1);
    cy   = s ? (va >= vb) : ((va + vb) > mask);
    r    = (s ? (va - vb) : (va + vb)) & mask;
    sa   = (va >= half) ? va - (mask + 1) : va;
    sb   = (vb >= half) ? vb - (mask + 1) : vb;
    t    = s ? (sa - sb) : (sa + sb);
    ov   = (t < -half) || (t >= half);
    for (int i = 0; i < k; i++) begin
      exp_q.push_back('{W'((r >> (W * i)) & 15), (i == k - 1), cy, ov,
                        (i == k - 1) && (n > MAXD), CW'(k)});
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1;
    total++;
    if ({out_vld, out_sum, out_last, out_carry, out_ovf, out_err, out_len} !== '0) begin
      bad++;
      $display("FAIL reset got vld=%b sum=%h last=%b c=%b ovf=%b err=%b len=%0d want all 0",
               out_vld, out_sum, out_last, out_carry, out_ovf, out_err, out_len);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL reset_quiet got %0d outputs want 0", got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_add;
    got_q.delete();
    beat(1'b0, 1'b0, 4'h7, 4'h9);
    beat(1'b1, 1'b0, 4'h3, 4'h2);
    idle(2);
    total++;
    if (got_q.size() != 2) begin
      bad++; $display("FAIL add_count got=%0d want=2", got_q.size());
    end else begin
      total++;
      if ({got_q[0].sum, got_q[0].lst, got_q[0].err, got_q[1].sum, got_q[1].lst} !== {4'h0, 1'b0, 1'b0, 4'h6, 1'b1}) begin
        bad++; $display("FAIL add_digits got=%h,%h last=%b,%b want=0,6 last=0,1",
                        got_q[0].sum, got_q[1].sum, got_q[0].lst, got_q[1].lst);
      end
      total++;
      if ({got_q[1].carry, got_q[1].ovf, got_q[1].err, got_q[1].len} !== {1'b0, 1'b0, 1'b0, 3'd2}) begin
        bad++; $display("FAIL add_flags got c=%b ovf=%b err=%b len=%0d want c=0 ovf=0 err=0 len=2",
                        got_q[1].carry, got_q[1].ovf, got_q[1].err, got_q[1].len);
      end
    end
  endtask

  task automatic test_sub;
    got_q.delete();
    beat(1'b0, 1'b1, 4'h0, 4'h1);
    beat(1'b1, 1'b0, 4'h1, 4'h0);
    idle(2);
    total++;
    if (got_q.size() != 2) begin
      bad++; $display("FAIL sub_count got=%0d want=2", got_q.size());
    end else begin
      total++;
      if ({got_q[0].sum, got_q[1].sum, got_q[1].lst, got_q[1].carry, got_q[1].ovf, got_q[1].len} !== {4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 3'd1 + 3'd1}) begin
        bad++; $display("FAIL sub_word got=%h,%h last=%b c=%b ovf=%b len=%0d want=f,0 last=1 c=1 ovf=0 len=2",
                        got_q[0].sum, got_q[1].sum, got_q[1].lst, got_q[1].carry, got_q[1].ovf, got_q[1].len);
      end
    end
  endtask

  task automatic test_overflow;
    got_q.delete();
    beat(1'b0, 1'b0, 4'hF, 4'h1);
    beat(1'b1, 1'b0, 4'h7, 4'h0);
    beat(1'b0, 1'b0, 4'hF, 4'h1);
    beat(1'b1, 1'b0, 4'hF, 4'h0);
    idle(2);
    total++;
    if (got_q.size() != 4) begin
      bad++; $display("FAIL ovf_count got=%0d want=4", got_q.size());
    end else begin
      total++;
      if ({got_q[0].sum, got_q[1].sum, got_q[1].carry, got_q[1].ovf} !== {4'h0, 4'h8, 1'b0, 1'b1}) begin
        bad++; $display("FAIL ovf_7f got=%h%h c=%b ovf=%b want=80 c=0 ovf=1",
                        got_q[1].sum, got_q[0].sum, got_q[1].carry, got_q[1].ovf);
      end
      total++;
      if ({got_q[2].sum, got_q[3].sum, got_q[3].carry, got_q[3].ovf} !== {4'h0, 4'h0, 1'b1, 1'b0}) begin
        bad++; $display("FAIL ovf_ff got=%h%h c=%b ovf=%b want=00 c=1 ovf=0",
                        got_q[3].sum, got_q[2].sum, got_q[3].carry, got_q[3].ovf);
      end
    end
  endtask

  task automatic test_gaps;
    got_q.delete();
    idle(1);
    beat(1'b0, 1'b0, 4'h7, 4'h9);
    vld = 1'b0; last = 1'b1; @(posedge clk); #1;
    vld = 1'b0; last = 1'b1; @(negedge clk);
    total++;
    if (out_vld !== 1'b0 || out_last !== 1'b0) begin
      bad++; $display("FAIL gap_quiet got vld=%b last=%b want 0,0", out_vld, out_last);
    end
    @(posedge clk); #1;
    idle(2);
    beat(1'b1, 1'b0, 4'h3, 4'h2);
    idle(2);
    total++;
    if (got_q.size() != 2) begin
      bad++; $display("FAIL gap_count got=%0d want=2", got_q.size());
    end else begin
      total++;
      if ({got_q[0].sum, got_q[0].lst, got_q[1].sum, got_q[1].lst, got_q[1].carry, got_q[1].len} !== {4'h0, 1'b0, 4'h6, 1'b1, 1'b0, 3'd2}) begin
        bad++; $display("FAIL gap_word got=%h,%h last=%b,%b c=%b len=%0d want=0,6 last=0,1 c=0 len=2",
                        got_q[0].sum, got_q[1].sum, got_q[0].lst, got_q[1].lst, got_q[1].carry, got_q[1].len);
      end
    end
  endtask

  task automatic test_truncate;
    got_q.delete();
    for (int i = 0; i < 6; i++) begin
      beat(i == 5, 1'b0, 4'hF, 4'h1);
    end
    beat(1'b1, 1'b0, 4'h2, 4'h3);
    idle(2);
    total++;
    if (got_q.size() != 5) begin
      bad++; $display("FAIL trunc_count got=%0d want=5", got_q.size());
    end else begin
      total++;
      if ({got_q[0].sum, got_q[1].sum, got_q[2].sum, got_q[3].sum, got_q[2].lst} !== {4'h0, 4'h1, 4'h1, 4'h1, 1'b0}) begin
        bad++; $display("FAIL trunc_digits got=%h,%h,%h,%h want=0,1,1,1",
                        got_q[0].sum, got_q[1].sum, got_q[2].sum, got_q[3].sum);
      end
      total++;
      if ({got_q[3].lst, got_q[3].err, got_q[3].len, got_q[3].carry, got_q[3].ovf} !== {1'b1, 1'b1, 3'd4, 1'b1, 1'b0}) begin
        bad++; $display("FAIL trunc_flags got last=%b err=%b len=%0d c=%b ovf=%b want 1 1 4 1 0",
                        got_q[3].lst, got_q[3].err, got_q[3].len, got_q[3].carry, got_q[3].ovf);
      end
      total++;
      if ({got_q[4].sum, got_q[4].lst, got_q[4].err, got_q[4].len, got_q[4].carry} !== {4'h5, 1'b1, 1'b0, 3'd1, 1'b0}) begin
        bad++; $display("FAIL trunc_next got sum=%h last=%b err=%b len=%0d c=%b want 5 1 0 1 0",
                        got_q[4].sum, got_q[4].lst, got_q[4].err, got_q[4].len, got_q[4].carry);
      end
    end
  endtask

  task automatic test_back_to_back;
    got_q.delete();
    beat(1'b0, 1'b0, 4'h7, 4'h9);
    beat(1'b1, 1'b0, 4'h3, 4'h2);
    beat(1'b0, 1'b1, 4'h0, 4'h1);
    beat(1'b1, 1'b0, 4'h1, 4'h0);
    beat(1'b1, 1'b1, 4'h5, 4'h5);
    idle(2);
    total++;
    if (got_q.size() != 5) begin
      bad++; $display("FAIL b2b_count got=%0d want=5", got_q.size());
    end else begin
      total++;
      if ({got_q[0].sum, got_q[1].sum, got_q[2].sum, got_q[3].sum, got_q[4].sum} !== {4'h0, 4'h6, 4'hF, 4'h0, 4'h0}) begin
        bad++; $display("FAIL b2b_digits got=%h,%h,%h,%h,%h want=0,6,f,0,0",
                        got_q[0].sum, got_q[1].sum, got_q[2].sum, got_q[3].sum, got_q[4].sum);
      end
      total++;
      if ({got_q[1].carry, got_q[3].carry, got_q[4].carry, got_q[4].len, got_q[2].lst, got_q[4].lst} !== {1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1}) begin
        bad++; $display("FAIL b2b_flags got c=%b,%b,%b len=%0d last2=%b last4=%b want 0,1,1 len=1 0 1",
                        got_q[1].carry, got_q[3].carry, got_q[4].carry, got_q[4].len, got_q[2].lst, got_q[4].lst);
      end
    end
  endtask

  task automatic test_async_reset;
    got_q.delete();
    beat(1'b0, 1'b0, 4'h3, 4'h4);
    vld = 1'b1; last = 1'b0; sub = 1'b0; a = 4'h1; b = 4'h1;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({out_vld, out_sum, out_last, out_carry, out_ovf, out_err, out_len} !== '0) begin
      bad++; $display("FAIL async_rst got vld=%b sum=%h last=%b c=%b ovf=%b err=%b len=%0d want all 0",
                      out_vld, out_sum, out_last, out_carry, out_ovf, out_err, out_len);
    end
    vld = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    got_q.delete();
    beat(1'b1, 1'b1, 4'h5, 4'h5);
    idle(2);
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL async_count got=%0d want=1", got_q.size());
    end else begin
      total++;
      if ({got_q[0].sum, got_q[0].lst, got_q[0].carry, got_q[0].ovf, got_q[0].err, got_q[0].len} !== {4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1}) begin
        bad++; $display("FAIL async_word got sum=%h last=%b c=%b ovf=%b err=%b len=%0d want 0 1 1 0 0 1",
                        got_q[0].sum, got_q[0].lst, got_q[0].carry, got_q[0].ovf, got_q[0].err, got_q[0].len);
      end
    end
  endtask

  task automatic test_random;
    int   n;
    logic s;
    got_q.delete();
    exp_q.delete();
    for (int w = 0; w < 60; w++) begin
      n = $urandom_range(1, 6);
      s = 1'($urandom);
      for (int i = 0; i < n; i++) begin
        wa[i] = W'($urandom);
        wb[i] = W'($urandom);
      end
      model_word(n, s);
      for (int i = 0; i < n; i++) begin
        if (w < 30) idle($urandom_range(0, 2));
        beat(i == n - 1, (i == 0) ? s : 1'($urandom), wa[i], wb[i]);
      end
    end
    idle(3);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].sum !== exp_q[i].sum || got_q[i].lst !== exp_q[i].lst ||
          got_q[i].err !== exp_q[i].err ||
          (exp_q[i].lst && (got_q[i].carry !== exp_q[i].carry ||
                            got_q[i].ovf !== exp_q[i].ovf ||
                            got_q[i].len !== exp_q[i].len))) begin
        bad++;
        $display("FAIL rand_digit[%0d] got sum=%h last=%b c=%b ovf=%b err=%b len=%0d want sum=%h last=%b c=%b ovf=%b err=%b len=%0d",
                 i, got_q[i].sum, got_q[i].lst, got_q[i].carry, got_q[i].ovf, got_q[i].err, got_q[i].len,
                 exp_q[i].sum, exp_q[i].lst, exp_q[i].carry, exp_q[i].ovf, exp_q[i].err, exp_q[i].len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_gaps();
    test_truncate();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
